// File: rtl/hdr_flit_inject_sched_pkg.sv
// -----------------------------------------------------------------------------
// hdr_flit_inject_sched_pkg
// Shared definitions for the NI injection scheduler:
//   - flit flag encodings placed in flit[Fw-1:Fw-2] ({hdr, tail})
//   - scheduler FSM state enum
//   - header payload field offsets
//   - helpers for the derived payload width and credit counter width
// -----------------------------------------------------------------------------
package hdr_flit_inject_sched_pkg;

    // {hdr, tail} flag pairs
    localparam logic [1:0] FLAG_HDR    = 2'b10;
    localparam logic [1:0] FLAG_BODY   = 2'b00;
    localparam logic [1:0] FLAG_TAIL   = 2'b01;
    localparam logic [1:0] FLAG_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } inj_state_e;

    // Header payload layout: {0..., class, dest, src}
    localparam int HDR_SRC_LSB = 0;

    function automatic int hdr_dest_lsb(input int eaw);
        return eaw;
    endfunction

    function automatic int hdr_class_lsb(input int eaw);
        return 2 * eaw;
    endfunction

    // Payload bits left after the two flag bits and the one-hot VC field
    function automatic int fpay_w(input int fw, input int v);
        return fw - 2 - v;
    endfunction

    // Counter must hold every value 0..B inclusive
    function automatic int cred_w(input int b);
        return $clog2(b + 1);
    endfunction

endpackage

// File: rtl/hdr_inj_rr_arbiter.sv
// -----------------------------------------------------------------------------
// hdr_inj_rr_arbiter
// N-way round-robin arbiter. Grants the first requester at or after the
// internal pointer. The pointer moves to winner+1 (mod N) only when the
// caller pulses 'advance', so the grant can be evaluated every cycle without
// disturbing fairness.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (pointer -> 0)
//   req         : request vector
//   advance     : accept the current grant and move the pointer past it
//   grant       : one-hot combinational grant (0 when no request)
//   grant_idx   : binary index of the granted requester
// -----------------------------------------------------------------------------
module hdr_inj_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic          found;
    int            k;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        k         = 0;
        for (int i = 0; i < N; i++) begin
            // Walk requesters starting at the pointer, wrapping at N
            k = i + int'(ptr);
            if (k >= N) begin
                k = k - N;
            end
            if (!found && req[IW'(k)]) begin
                found            = 1'b1;
                grant[IW'(k)]    = 1'b1;
                grant_idx        = IW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/hdr_flit_inject_sched.sv
// -----------------------------------------------------------------------------
// hdr_flit_inject_sched
// Injection-side scheduler for one NI port. Round-robin picks a requesting
// source, emits its header flit, then streams body/tail flits from that
// source's payload bus, gating every flit on a per-VC credit counter.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   src_e_addr_i      : local endpoint address (header src field)
//   req_i             : per-source packet request
//   req_dest_i        : per-source destination address (N*EAw)
//   req_class_i       : per-source class (N*Cw)
//   req_vc_i          : per-source one-hot VC (N*V)
//   req_len_i         : per-source packet length in flits, 0 means 1 (N*LENw)
//   req_data_i        : per-source current body payload (N*FPAYw)
//   grant_o           : one-hot owner of the datapath, held for the packet
//   data_rd_o         : pulse in the cycle a source's payload is consumed
//   flit_out          : {hdr, tail, vc[V-1:0], payload[FPAYw-1:0]}
//   flit_out_wr       : flit valid strobe
//   credit_in         : per-VC single-cycle credit return
//   busy_o            : scheduler is not idle
//   stall_err_o       : sticky credit-stall watchdog flag
//
// Flow control: there is no ready toward the router; a flit may be written
// only while the chosen VC holds a credit. flit_out_wr is a one-cycle valid,
// each write consumes one credit of the flit's VC, and each credit_in[v]
// pulse returns one. data_rd_o[s] is the matching "ready" toward source s:
// req_data_i[s] is taken in exactly the cycle data_rd_o[s] is high.
//
// Optional feature: define HDR_INJ_STALL_WATCHDOG_EN to build the stall
// watchdog (threshold STALL_MAX); otherwise stall_err_o is constant 0.
// -----------------------------------------------------------------------------
module hdr_flit_inject_sched
    import hdr_flit_inject_sched_pkg::*;
#(
    parameter int N         = 4,
    parameter int V         = 2,
    parameter int EAw       = 6,
    parameter int Cw        = 1,
    parameter int Fw        = 32,
    parameter int LENw      = 8,
    parameter int B         = 4,
    parameter int STALL_MAX = 1023
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [EAw-1:0]               src_e_addr_i,
    input  logic [N-1:0]                 req_i,
    input  logic [N*EAw-1:0]             req_dest_i,
    input  logic [N*Cw-1:0]              req_class_i,
    input  logic [N*V-1:0]               req_vc_i,
    input  logic [N*LENw-1:0]            req_len_i,
    input  logic [N*fpay_w(Fw, V)-1:0]   req_data_i,
    output logic [N-1:0]                 grant_o,
    output logic [N-1:0]                 data_rd_o,
    output logic [Fw-1:0]                flit_out,
    output logic                         flit_out_wr,
    input  logic [V-1:0]                 credit_in,
    output logic                         busy_o,
    output logic                         stall_err_o
);

    localparam int FPAYW     = fpay_w(Fw, V);
    localparam int CRW       = cred_w(B);
    localparam int IW        = (N > 1) ? $clog2(N) : 1;
    localparam int DEST_LSB  = hdr_dest_lsb(EAw);
    localparam int CLASS_LSB = hdr_class_lsb(EAw);
    localparam logic [CRW-1:0] CRED_FULL = CRW'(B);

    inj_state_e      state;
    logic [IW-1:0]   win_idx;
    logic [EAw-1:0]  win_dest;
    logic [Cw-1:0]   win_class;
    logic [V-1:0]    win_vc;
    logic [LENw-1:0] win_len;
    logic [LENw-1:0] remaining;

    logic [CRW-1:0]  credit [V];
    logic [V-1:0]    cred_nz;
    logic            credit_ok;
    logic            send;

    logic [N-1:0]    arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            arb_advance;
    logic [LENw-1:0] req_len_sel;
    logic [FPAYW-1:0] hdr_payload;
    logic [FPAYW-1:0] body_payload;

    hdr_inj_rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_i),
        .advance   (arb_advance),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Credit check against the latched one-hot VC without decoding it
    always_comb begin
        for (int v = 0; v < V; v++) begin
            cred_nz[v] = (credit[v] != '0);
        end
    end

    assign credit_ok    = |(win_vc & cred_nz);
    assign send         = (state != ST_IDLE) && credit_ok;
    assign arb_advance  = (state == ST_IDLE) && (|req_i) && !reset;
    assign req_len_sel  = req_len_i[arb_idx*LENw +: LENw];
    assign body_payload = req_data_i[win_idx*FPAYW +: FPAYW];
    assign busy_o       = (state != ST_IDLE);

    always_comb begin
        hdr_payload = '0;
        hdr_payload[HDR_SRC_LSB +: EAw] = src_e_addr_i;
        hdr_payload[DEST_LSB +: EAw]    = win_dest;
        hdr_payload[CLASS_LSB +: Cw]    = win_class;
    end

    // Combinational so the pulse lines up with the cycle the payload is taken
    always_comb begin
        data_rd_o = '0;
        if (!reset && (state == ST_BODY) && credit_ok) begin
            data_rd_o[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            grant_o     <= '0;
            flit_out    <= '0;
            flit_out_wr <= 1'b0;
            win_idx     <= '0;
            win_dest    <= '0;
            win_class   <= '0;
            win_vc      <= '0;
            win_len     <= '0;
            remaining   <= '0;
        end else begin
            flit_out_wr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req_i) begin
                        win_idx   <= arb_idx;
                        win_dest  <= req_dest_i[arb_idx*EAw +: EAw];
                        win_class <= req_class_i[arb_idx*Cw +: Cw];
                        win_vc    <= req_vc_i[arb_idx*V +: V];
                        win_len   <= (req_len_sel == '0) ? LENw'(1) : req_len_sel;
                        grant_o   <= arb_grant;
                        state     <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (credit_ok) begin
                        flit_out_wr <= 1'b1;
                        if (win_len == LENw'(1)) begin
                            flit_out <= {FLAG_SINGLE, win_vc, hdr_payload};
                            grant_o  <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            flit_out  <= {FLAG_HDR, win_vc, hdr_payload};
                            remaining <= win_len - LENw'(1);
                            state     <= ST_BODY;
                        end
                    end
                end
                ST_BODY: begin
                    if (credit_ok) begin
                        flit_out_wr <= 1'b1;
                        remaining   <= remaining - LENw'(1);
                        if (remaining == LENw'(1)) begin
                            flit_out <= {FLAG_TAIL, win_vc, body_payload};
                            grant_o  <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            flit_out <= {FLAG_BODY, win_vc, body_payload};
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Per-VC credits; a send and a return in the same cycle cancel out.
    // A return while already full is dropped so the count never exceeds B.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < V; v++) begin
                credit[v] <= CRED_FULL;
            end
        end else begin
            for (int v = 0; v < V; v++) begin
                if (credit_in[v] && !(send && win_vc[v])) begin
                    if (credit[v] != CRED_FULL) begin
                        credit[v] <= credit[v] + CRW'(1);
                    end
                end else if (!credit_in[v] && send && win_vc[v]) begin
                    credit[v] <= credit[v] - CRW'(1);
                end
            end
        end
    end

`ifdef HDR_INJ_STALL_WATCHDOG_EN
    localparam int SW = ($clog2(STALL_MAX + 1) > 10) ? $clog2(STALL_MAX + 1) : 10;
    localparam logic [SW-1:0] STALL_LIM = SW'(STALL_MAX);

    logic [SW-1:0] stall_cnt;
    logic [SW-1:0] stall_next;
    logic          stall_err_q;

    // Counts consecutive credit-blocked cycles, saturating at all-ones
    always_comb begin
        stall_next = '0;
        if ((state != ST_IDLE) && !credit_ok) begin
            stall_next = (stall_cnt == '1) ? stall_cnt : stall_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt   <= '0;
            stall_err_q <= 1'b0;
        end else begin
            stall_cnt <= stall_next;
            if (stall_next >= STALL_LIM) begin
                stall_err_q <= 1'b1;
            end
        end
    end

    assign stall_err_o = stall_err_q;
`else
    logic unused_stall_max;
    assign unused_stall_max = ^STALL_MAX;
    assign stall_err_o      = 1'b0;
`endif

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (!reset && arb_advance) begin
            assert ($onehot(req_vc_i[arb_idx*V +: V]))
            else $error("hdr_flit_inject_sched: req_vc_i of source %0d not one-hot", arb_idx);
        end
        for (int v = 0; v < V; v++) begin
            if (!reset && credit_in[v] && !(send && win_vc[v]) && credit[v] == CRED_FULL) begin
                $display("hdr_flit_inject_sched: credit return on full VC %0d", v);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hdr_flit_inject_sched.sv
// -----------------------------------------------------------------------------
// tb_hdr_flit_inject_sched
// Directed bench for hdr_flit_inject_sched (N=4, V=2, EAw=6, Fw=32, B=4,
// STALL_MAX=20). Expected flits are queued when a request is driven and
// compared as flit_out_wr strobes appear. Watchdog expectations follow
// HDR_INJ_STALL_WATCHDOG_EN.
// -----------------------------------------------------------------------------
module tb_hdr_flit_inject_sched;

    localparam int N     = 4;
    localparam int V     = 2;
    localparam int EAW   = 6;
    localparam int CLW   = 1;
    localparam int FW    = 32;
    localparam int LENW  = 8;
    localparam int B     = 4;
    localparam int SMAX  = 20;
    localparam int FPAYW = FW - 2 - V;
    localparam logic [EAW-1:0] SRC = 6'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic [EAW-1:0]       src_e_addr_i;
    logic [N-1:0]         req_i;
    logic [N*EAW-1:0]     req_dest_i;
    logic [N*CLW-1:0]     req_class_i;
    logic [N*V-1:0]       req_vc_i;
    logic [N*LENW-1:0]    req_len_i;
    logic [N*FPAYW-1:0]   req_data_i;
    logic [N-1:0]         grant_o;
    logic [N-1:0]         data_rd_o;
    logic [FW-1:0]        flit_out;
    logic                 flit_out_wr;
    logic [V-1:0]         credit_in;
    logic                 busy_o;
    logic                 stall_err_o;

    hdr_flit_inject_sched #(
        .N(N), .V(V), .EAw(EAW), .Cw(CLW), .Fw(FW), .LENw(LENW), .B(B), .STALL_MAX(SMAX)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .src_e_addr_i (src_e_addr_i),
        .req_i        (req_i),
        .req_dest_i   (req_dest_i),
        .req_class_i  (req_class_i),
        .req_vc_i     (req_vc_i),
        .req_len_i    (req_len_i),
        .req_data_i   (req_data_i),
        .grant_o      (grant_o),
        .data_rd_o    (data_rd_o),
        .flit_out     (flit_out),
        .flit_out_wr  (flit_out_wr),
        .credit_in    (credit_in),
        .busy_o       (busy_o),
        .stall_err_o  (stall_err_o)
    );

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    int wr_count     = 0;
    int rd_count     = 0;
    logic [FW-1:0] exp_q[$];

    always @(negedge clk) begin
        logic [FW-1:0] e;
        if (!reset) begin
            rd_count += $countones(data_rd_o);
            if (flit_out_wr) begin
                wr_count++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $error("FAIL flit_unexpected got=%h want=none", flit_out);
                end else begin
                    e = exp_q.pop_front();
                    assert (flit_out === e)
                    else begin
                        tests_failed++;
                        $error("FAIL flit got=%h want=%h", flit_out, e);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL tb_timeout got=running want=finished");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp)
        else begin
            tests_failed++;
            $error("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic set_src(input int s, input logic [EAW-1:0] dest, input logic [CLW-1:0] cls,
                           input logic [V-1:0] vc, input logic [LENW-1:0] len,
                           input logic [FPAYW-1:0] data);
        req_dest_i[s*EAW +: EAW]    = dest;
        req_class_i[s*CLW +: CLW]   = cls;
        req_vc_i[s*V +: V]          = vc;
        req_len_i[s*LENW +: LENW]   = len;
        req_data_i[s*FPAYW +: FPAYW] = data;
    endtask

    function automatic logic [FW-1:0] exp_hdr(input logic [EAW-1:0] dest, input logic [CLW-1:0] cls,
                                              input logic [V-1:0] vc, input int len);
        logic [FPAYW-1:0] p;
        p = '0;
        p[EAW-1:0]     = SRC;
        p[2*EAW-1:EAW] = dest;
        p[2*EAW]       = cls;
        return {(len <= 1) ? 2'b11 : 2'b10, vc, p};
    endfunction

    function automatic logic [FW-1:0] exp_body(input bit last, input logic [V-1:0] vc,
                                               input logic [FPAYW-1:0] d);
        return {last ? 2'b01 : 2'b00, vc, d};
    endfunction

    task automatic push_pkt(input logic [EAW-1:0] dest, input logic [CLW-1:0] cls,
                            input logic [V-1:0] vc, input int len, input logic [FPAYW-1:0] d);
        exp_q.push_back(exp_hdr(dest, cls, vc, len));
        for (int i = 1; i < len; i++) begin
            exp_q.push_back(exp_body(i == len - 1, vc, d));
        end
    endtask

    task automatic return_credit(input int v);
        credit_in[v] = 1'b1;
        tick();
        credit_in = '0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy_o && n < budget) begin
            tick();
            n++;
        end
        check(tag, busy_o, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w0;
        int rd0;
        int n;
        int order [5];
        order = '{0, 1, 2, 3, 0};

        reset        = 1'b1;
        src_e_addr_i = SRC;
        req_i        = '0;
        req_dest_i   = '0;
        req_class_i  = '0;
        req_vc_i     = '0;
        req_len_i    = '0;
        req_data_i   = '0;
        credit_in    = '0;
        repeat (3) tick();

        check("rst_grant", grant_o, 0);
        check("rst_data_rd", data_rd_o, 0);
        check("rst_flit", flit_out, 0);
        check("rst_wr", flit_out_wr, 0);
        check("rst_busy", busy_o, 0);
        check("rst_stall", stall_err_o, 0);
        reset = 1'b0;
        tick();

        // 1: single-flit packet, header two cycles after request
        set_src(0, 6'd5, 1'b0, 2'b01, 8'd1, 24'h0);
        push_pkt(6'd5, 1'b0, 2'b01, 1, 24'h0);
        w0 = wr_count;
        req_i = 4'b0001;
        tick();
        check("t1_grant", grant_o, 4'b0001);
        check("t1_busy", busy_o, 1);
        check("t1_no_wr_yet", flit_out_wr, 0);
        req_i = '0;
        tick();
        check("t1_wr", flit_out_wr, 1);
        check("t1_payload", flit_out[11:0], 12'h143);
        check("t1_grant_clr", grant_o, 0);
        check("t1_count", wr_count - w0, 1);
        return_credit(0);

        // 2: 4-flit packet consumes all VC0 credits
        set_src(1, 6'd9, 1'b1, 2'b01, 8'd4, 24'hA1B2C3);
        push_pkt(6'd9, 1'b1, 2'b01, 4, 24'hA1B2C3);
        w0  = wr_count;
        rd0 = rd_count;
        req_i = 4'b0010;
        tick();
        req_i = '0;
        wait_idle(20, "t2_done");
        check("t2_flits", wr_count - w0, 4);
        check("t2_data_rd", rd_count - rd0, 3);

        // VC0 now empty: a len=0 (treated as 1) packet must stall in HDR
        set_src(2, 6'd17, 1'b0, 2'b01, 8'd0, 24'h0);
        push_pkt(6'd17, 1'b0, 2'b01, 1, 24'h0);
        w0 = wr_count;
        req_i = 4'b0100;
        tick();
        req_i = '0;
        repeat (5) tick();
        check("t2_zero_credit_stall", wr_count - w0, 0);
        check("t2_stall_busy", busy_o, 1);
        return_credit(0);
        tick();
        check("t2_release", wr_count - w0, 1);
        check("t2_release_idle", busy_o, 0);
        repeat (4) return_credit(0);

        // 3: 6-flit packet against 4 credits, one flit per return
        set_src(3, 6'd33, 1'b0, 2'b01, 8'd6, 24'h5A5A5A);
        push_pkt(6'd33, 1'b0, 2'b01, 6, 24'h5A5A5A);
        w0 = wr_count;
        req_i = 4'b1000;
        tick();
        req_i = '0;
        repeat (8) tick();
        check("t3_burst", wr_count - w0, 4);
        check("t3_stalled", busy_o, 1);
        return_credit(0);
        repeat (3) tick();
        check("t3_release1", wr_count - w0, 5);
        return_credit(0);
        repeat (3) tick();
        check("t3_release2", wr_count - w0, 6);
        check("t3_idle", busy_o, 0);
        repeat (4) return_credit(0);

        // 4: fairness on VC1, all four requesting
        for (int s = 0; s < N; s++) begin
            set_src(s, 6'(10 + s), CLW'(s == 2), 2'b10, 8'd2, 24'(32'h100000 + s));
        end
        for (int k = 0; k < 5; k++) begin
            push_pkt(6'(10 + order[k]), CLW'(order[k] == 2), 2'b10, 2, 24'(32'h100000 + order[k]));
        end
        req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (grant_o == '0 && n < 20) begin
                tick();
                n++;
            end
            check("t4_grant", grant_o, 4'b0001 << order[k]);
            if (k == 4) begin
                req_i = '0;
            end
            n = 0;
            while (grant_o != '0 && n < 20) begin
                tick();
                n++;
            end
            check("t4_grant_drop", grant_o, 0);
            return_credit(1);
            return_credit(1);
        end

        // 5: reset after 2 of 5 flits
        set_src(1, 6'd44, 1'b0, 2'b01, 8'd5, 24'hC0FFEE);
        push_pkt(6'd44, 1'b0, 2'b01, 5, 24'hC0FFEE);
        w0 = wr_count;
        req_i = 4'b0010;
        tick();
        req_i = '0;
        n = 0;
        while ((wr_count - w0) < 2 && n < 20) begin
            tick();
            n++;
        end
        check("t5_two_sent", wr_count - w0, 2);
        reset = 1'b1;
        tick();
        check("t5_busy", busy_o, 0);
        check("t5_grant", grant_o, 0);
        check("t5_wr", flit_out_wr, 0);
        check("t5_flit", flit_out, 0);
        check("t5_data_rd", data_rd_o, 0);
        exp_q.delete();
        reset = 1'b0;
        tick();

        // Pointer back at 0: sources 0 and 3 requesting, 0 wins first
        set_src(0, 6'd21, 1'b0, 2'b10, 8'd1, 24'h0);
        set_src(3, 6'd22, 1'b1, 2'b10, 8'd1, 24'h0);
        push_pkt(6'd21, 1'b0, 2'b10, 1, 24'h0);
        push_pkt(6'd22, 1'b1, 2'b10, 1, 24'h0);
        req_i = 4'b1001;
        tick();
        check("t5_ptr_reset", grant_o, 4'b0001);
        tick();
        tick();
        check("t5_ptr_next", grant_o, 4'b1000);
        req_i = '0;
        wait_idle(10, "t5_pair_done");
        repeat (2) return_credit(1);

        // Credits back at B: a 4-flit packet runs without any return
        set_src(1, 6'd45, 1'b0, 2'b01, 8'd4, 24'h123456);
        push_pkt(6'd45, 1'b0, 2'b01, 4, 24'h123456);
        w0 = wr_count;
        req_i = 4'b0010;
        tick();
        req_i = '0;
        wait_idle(20, "t5_cred_restored");
        check("t5_cred_flits", wr_count - w0, 4);

        // 6: VC0 empty, single-flit packet blocked in HDR
        set_src(0, 6'd7, 1'b0, 2'b01, 8'd1, 24'h0);
        push_pkt(6'd7, 1'b0, 2'b01, 1, 24'h0);
        req_i = 4'b0001;
        tick();
        req_i = '0;
        repeat (19) tick();
        check("t6_before_limit", stall_err_o, 0);
        tick();
`ifdef HDR_INJ_STALL_WATCHDOG_EN
        check("t6_at_limit", stall_err_o, 1);
`else
        check("t6_at_limit", stall_err_o, 0);
`endif
        repeat (5) return_credit(0);
        repeat (2) tick();
`ifdef HDR_INJ_STALL_WATCHDOG_EN
        check("t6_sticky", stall_err_o, 1);
`else
        check("t6_sticky", stall_err_o, 0);
`endif
        check("t6_idle", busy_o, 0);

        repeat (3) tick();
        check("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hdr_flit_inject_sched.md
Name: hdr_flit_inject_sched

Overview:
Injection-side scheduler for one NI port. It shares a single header-flit/flit-output datapath among N local traffic sources.
- Arbitrates round-robin between packet requests.
- Builds the header flit (hdr flag, one-hot VC, src/dest address, class), then streams body/tail flits from the winner's data bus.
- Gates every flit on per-VC credit counters.
- Sits between the traffic generators/DMA engines and the router's local input port.

Parameters:
N, 4, number of requesters (>=2)
V, 2, number of VCs (one-hot VC field)
EAw, 6, endpoint address width
Cw, 1, class field width
Fw, 32, flit width; FPAYw = Fw-2-V, and FPAYw >= 2*EAw+Cw
LENw, 8, packet-length field width (flits)
B, 4, buffer depth per VC at the router input; credit counter reset value
STALL_MAX, 1023, watchdog threshold in cycles (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
src_e_addr_i  in  EAw  this endpoint's address, placed in every header
req_i  in  N  packet request per source
req_dest_i  in  N*EAw  destination address per source
req_class_i  in  N*Cw  class per source
req_vc_i  in  N*V  one-hot VC per source
req_len_i  in  N*LENw  packet length in flits; 0 is treated as 1
req_data_i  in  N*FPAYw  current body payload per source
grant_o  out  N  one-hot; held for the whole packet
data_rd_o  out  N  1-cycle pulse when a body/tail payload is consumed
flit_out  out  Fw  flit to the router: [Fw-1]=hdr, [Fw-2]=tail, [Fw-3:FPAYw]=VC, [FPAYw-1:0]=payload
flit_out_wr  out  1  flit valid strobe
credit_in  in  V  one-cycle credit return per VC
busy_o  out  1  FSM not in IDLE
stall_err_o  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on port reset.
- Reset values: FSM=IDLE; grant_o=0; data_rd_o=0; flit_out=0; flit_out_wr=0; busy_o=0; stall_err_o=0; all credit counters=B; rr pointer=0; flit counter=0.
- FSM states: IDLE, HDR, BODY.
- IDLE:
  - If any req_i is set, the round-robin arbiter selects the first requester at or after the pointer.
  - Latch the winner's index, dest, class, VC and length (len=0 becomes 1).
  - grant_o for the winner rises next cycle. Pointer advances to winner+1 mod N. Go to HDR.
- HDR:
  - If credit[vc]>0: register the header flit and pulse flit_out_wr in the next cycle.
  - Header payload: [EAw-1:0]=src, [2EAw-1:EAw]=dest, [2EAw+Cw-1:2EAw]=class, rest 0.
  - Flag bits: 2'b10, or 2'b11 if len==1. If len==1, go to IDLE; otherwise remaining=len-1 and go to BODY.
  - If no credit, stay in HDR with no write.
- BODY:
  - If credit[vc]>0: emit {2'b00 or 2'b01 on the last flit, vc, req_data_i[winner]} and pulse data_rd_o[winner] in the same cycle the payload is sampled. Decrement remaining.
  - After the tail flit, go to IDLE; grant_o drops in the cycle IDLE is entered.
- Latency: request to header flit_out_wr is 2 cycles with credit available. Back-to-back flits at 1 per cycle while credit lasts. One dead IDLE cycle between packets.
- Credits (per VC):
  - Decrement on a flit sent on that VC; increment on credit_in[v]; simultaneous send+return leaves the count unchanged.
  - A counter never exceeds B. A return while the count is at B is an error and is flagged by a SIMULATION-only $display.
  - Credits are tracked for all VCs, including ones not currently granted.
- Requests: req_i may drop while granted. It is ignored; the packet always completes (no abort).
- Reset mid-packet: abandon immediately to the reset state. A partially sent packet is the upstream layer's problem.
- Errors: a req_vc_i that is not one-hot gives undefined behaviour and is checked by a SIMULATION-only assertion.

Optional Feature:
Macro HDR_INJ_STALL_WATCHDOG_EN.
- Defined: a 10-bit+ saturating counter increments in each HDR/BODY cycle blocked by zero credit and clears on any flit sent or in IDLE. When it reaches STALL_MAX, stall_err_o is set and stays set until reset.
- Undefined: no counter is built; stall_err_o is tied to 0.

Decomposition:
- Shared package: flit flag constants (HDR=2'b10, BODY=2'b00, TAIL=2'b01, SINGLE=2'b11), the FSM state enum, header field offset localparams, and the derived FPAYw and credit width $clog2(B+1).
- One sub-module: hdr_inj_rr_arbiter (N-way round-robin, one-hot grant, external pointer-advance strobe).

Test Plan:
1. Single-flit packet: req_i=0001, len=1, vc=01, dest=5, src=3 -> 2 cycles later one flit, flags 11, VC 01, payload[11:0]=0x143; grant_o clears.
2. 4-flit packet with B=4 and no credit returns -> header plus 3 flits back-to-back, flags 10/00/00/01, data_rd_o pulses 3x; credit[0] ends at 0.
3. Credit stall: 6-flit packet, B=4 -> 4 flits, then no writes until credit_in[0] pulses; each return releases exactly one flit.
4. Fairness: req_i=1111 held, every len=2 -> grant order 0,1,2,3,0.
5. Reset asserted mid-BODY (2 of 5 flits sent) -> next cycle FSM=IDLE, outputs 0, credits=B.
6. With the macro defined, STALL_MAX=20 and zero credits -> stall_err_o sets after 20 blocked cycles and stays 1 after credits return.
